// File: rtl/soma_sweep_if.sv
// Bus bundle between the soma sweep engine and its neighbours.
//  soma_sd_re / soma_sd_addr : read strobe and address towards the dendrite (SD) stage
//  sd_soma_vm                : dendritic sum returned one cycle after the strobe
//  soma_spk_valid / _addr    : spike offered to the spike-out stage
//  spk_soma_ready            : spike-out stage accepts when valid && ready
// master = soma side, slave = SD / spike-out side.
interface soma_sweep_if #(
    parameter int NNW = 12,
    parameter int VW  = 20
);
    logic           soma_sd_re;
    logic [NNW-1:0] soma_sd_addr;
    logic [VW-1:0]  sd_soma_vm;
    logic           soma_spk_valid;
    logic [NNW-1:0] soma_spk_addr;
    logic           spk_soma_ready;

    modport master (
        output soma_sd_re, soma_sd_addr, soma_spk_valid, soma_spk_addr,
        input  sd_soma_vm, spk_soma_ready
    );

    modport slave (
        input  soma_sd_re, soma_sd_addr, soma_spk_valid, soma_spk_addr,
        output sd_soma_vm, spk_soma_ready
    );
endinterface

// File: rtl/soma_sweep.sv
// Self-sequencing neuron-update engine. One start pulse sweeps neurons 0..nnum:
// each neuron's {refractory, Vm} word is read from the internal RAM, integrated
// with the dendritic sum from SD (saturating), leaked, fired/reset and written
// back; spikes leave over a valid/ready port.
// Ports:
//  clk_soma, rst_n          clock, asynchronous active-low reset
//  soma_start/busy/done     sweep control
//  config_soma_*            sweep configuration, latched on an accepted start
//  bus (master)             SD read port and spike output handshake
//  config_soma_vm_*         host Vm read/write port, honoured only when idle
module soma_sweep #(
    parameter int NNW = 12,
    parameter int VW  = 20,
    parameter int RW  = 4
) (
    input  logic           clk_soma,
    input  logic           rst_n,
    input  logic           soma_start,
    output logic           soma_busy,
    output logic           soma_done,
    input  logic [1:0]     config_soma_code,
    input  logic [1:0]     config_soma_rmode,
    input  logic [VW-1:0]  config_soma_vth,
    input  logic [VW-1:0]  config_soma_leak,
    input  logic [VW-1:0]  config_soma_vreset,
    input  logic [RW-1:0]  config_soma_refrac,
    input  logic [NNW-1:0] config_soma_nnum,
    soma_sweep_if.master   bus,
    input  logic           config_soma_vm_we,
    input  logic [NNW-1:0] config_soma_vm_waddr,
    input  logic [VW-1:0]  config_soma_vm_wdata,
    input  logic           config_soma_vm_re,
    input  logic [NNW-1:0] config_soma_vm_raddr,
    output logic [VW-1:0]  config_soma_vm_rdata
);
    localparam int WW = RW + VW;
    localparam int XW = VW + 2;   // two guard bits: Vm + s - leak cannot overflow
    localparam logic signed [XW-1:0] SAT_MAX_C = {3'b000, {(VW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN_C = {3'b111, {(VW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_UPD  = 3'd2,
        S_SPK  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic signed [XW-1:0] sext(input logic [VW-1:0] a);
        return {{2{a[VW-1]}}, a};
    endfunction

    function automatic logic [VW-1:0] sat_vw(input logic signed [XW-1:0] x);
        logic [VW-1:0] r;
        if (x > SAT_MAX_C) begin
            r = SAT_MAX_C[VW-1:0];
        end else if (x < SAT_MIN_C) begin
            r = SAT_MIN_C[VW-1:0];
        end else begin
            r = x[VW-1:0];
        end
        return r;
    endfunction

    state_t         state_r, next_s;
    logic [WW-1:0]  mem [2**NNW];
    logic [WW-1:0]  ram_q_r;
    logic [NNW-1:0] addr_r, addr_s;
    logic [1:0]     code_r, rmode_r;
    logic [VW-1:0]  vth_r, leak_r, vreset_r;
    logic [RW-1:0]  refrac_r;
    logic [NNW-1:0] nnum_r;
    logic           busy_r, done_r, sd_re_r, spk_valid_r;
    logic [NNW-1:0] sd_addr_r, spk_addr_r, spk_addr_s, sd_addr_s;
    logic [VW-1:0]  rdata_r;
    logic           busy_s, done_s, sd_re_s, spk_valid_s;
    logic           last_s, fire_s, host_we_s, host_re_s;
    logic [VW-1:0]  vm_old_s, v_s, vm_new_s;
    logic [RW-1:0]  ref_old_s;
    logic signed [XW-1:0] sum_s, leak_term_s;
    logic [WW-1:0]  new_word_s;

    assign soma_busy            = busy_r;
    assign soma_done            = done_r;
    assign bus.soma_sd_re       = sd_re_r;
    assign bus.soma_sd_addr     = sd_addr_r;
    assign bus.soma_spk_valid   = spk_valid_r;
    assign bus.soma_spk_addr    = spk_addr_r;
    assign config_soma_vm_rdata = rdata_r;

    assign last_s    = (addr_r == nnum_r);
    assign host_we_s = config_soma_vm_we && !busy_r;
    assign host_re_s = config_soma_vm_re && !busy_r;

    // Neuron update: integrate, saturate, fire test and reset-mode selection.
    always_comb begin
        vm_old_s    = ram_q_r[VW-1:0];
        ref_old_s   = ram_q_r[WW-1:VW];
        leak_term_s = (code_r == 2'b00) ? sext(leak_r) : {XW{1'b0}};
        sum_s       = sext(vm_old_s) + sext(bus.sd_soma_vm) - leak_term_s;
        v_s         = sat_vw(sum_s);
        fire_s      = 1'b0;
        vm_new_s    = v_s;
        new_word_s  = ram_q_r;
        case (code_r)
            2'b00, 2'b01: begin
                if (ref_old_s != {RW{1'b0}}) begin
                    // Refractory: hold Vm, discard the dendritic sum.
                    new_word_s = {ref_old_s - {{(RW-1){1'b0}}, 1'b1}, vm_old_s};
                end else if ($signed(v_s) >= $signed(vth_r)) begin
                    fire_s = 1'b1;
                    case (rmode_r)
                        2'b00:   vm_new_s = v_s;
                        2'b10:   vm_new_s = sat_vw(sext(v_s) - sext(vth_r));
                        default: vm_new_s = vreset_r;
                    endcase
                    new_word_s = {refrac_r, vm_new_s};
                end else begin
                    new_word_s = {{RW{1'b0}}, v_s};
                end
            end
            2'b10:   new_word_s = ram_q_r;
            default: new_word_s = {WW{1'b0}};
        endcase
    end

    // Next-state logic of the sweep sequencer.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (soma_start) begin
                    next_s = S_RD;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_RD:  next_s = S_UPD;
            S_UPD: begin
                if (fire_s) begin
                    next_s = S_SPK;
                end else if (last_s) begin
                    next_s = S_DONE;
                end else begin
                    next_s = S_RD;
                end
            end
            S_SPK: begin
                if (bus.spk_soma_ready) begin
                    next_s = last_s ? S_DONE : S_RD;
                end else begin
                    next_s = S_SPK;
                end
            end
            S_DONE:  next_s = S_IDLE;
            default: next_s = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the neuron address.
    always_comb begin
        busy_s      = (next_s == S_RD) || (next_s == S_UPD) || (next_s == S_SPK);
        done_s      = (next_s == S_DONE);
        sd_re_s     = (next_s == S_RD);
        spk_valid_s = (next_s == S_SPK);
        addr_s      = addr_r;
        spk_addr_s  = spk_addr_r;
        case (state_r)
            S_IDLE: begin
                if (soma_start) begin
                    addr_s = {NNW{1'b0}};
                end else begin
                    addr_s = addr_r;
                end
            end
            S_UPD: begin
                if (fire_s) begin
                    spk_addr_s = addr_r;
                end else if (!last_s) begin
                    addr_s = addr_r + {{(NNW-1){1'b0}}, 1'b1};
                end else begin
                    addr_s = addr_r;
                end
            end
            S_SPK: begin
                if (bus.spk_soma_ready && !last_s) begin
                    addr_s = addr_r + {{(NNW-1){1'b0}}, 1'b1};
                end else begin
                    addr_s = addr_r;
                end
            end
            default: addr_s = addr_r;
        endcase
        sd_addr_s = sd_re_s ? addr_s : sd_addr_r;
    end

    // Sequencer state register.
    always_ff @(posedge clk_soma or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Registered outputs, neuron address and host read data.
    always_ff @(posedge clk_soma or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sd_re_r     <= 1'b0;
            spk_valid_r <= 1'b0;
            sd_addr_r   <= {NNW{1'b0}};
            spk_addr_r  <= {NNW{1'b0}};
            addr_r      <= {NNW{1'b0}};
            rdata_r     <= {VW{1'b0}};
        end else begin
            busy_r      <= busy_s;
            done_r      <= done_s;
            sd_re_r     <= sd_re_s;
            spk_valid_r <= spk_valid_s;
            sd_addr_r   <= sd_addr_s;
            spk_addr_r  <= spk_addr_s;
            addr_r      <= addr_s;
            if (host_re_s) begin
                rdata_r <= mem[config_soma_vm_raddr][VW-1:0];
            end
        end
    end

    // Sweep configuration, frozen for the duration of a sweep.
    always_ff @(posedge clk_soma or negedge rst_n) begin
        if (!rst_n) begin
            code_r   <= 2'b00;
            rmode_r  <= 2'b00;
            vth_r    <= {VW{1'b0}};
            leak_r   <= {VW{1'b0}};
            vreset_r <= {VW{1'b0}};
            refrac_r <= {RW{1'b0}};
            nnum_r   <= {NNW{1'b0}};
        end else if (state_r == S_IDLE && soma_start) begin
            code_r   <= config_soma_code;
            rmode_r  <= config_soma_rmode;
            vth_r    <= config_soma_vth;
            leak_r   <= config_soma_leak;
            vreset_r <= config_soma_vreset;
            refrac_r <= config_soma_refrac;
            nnum_r   <= config_soma_nnum;
        end
    end

    // Neuron state RAM: sweep write-back has the port while busy, host otherwise.
    always_ff @(posedge clk_soma) begin
        if (state_r == S_UPD) begin
            mem[addr_r] <= new_word_s;
        end else if (host_we_s) begin
            mem[config_soma_vm_waddr] <= {{RW{1'b0}}, config_soma_vm_wdata};
        end
        if (state_r == S_RD) begin
            ram_q_r <= mem[addr_r];
        end
    end
endmodule
